// File: rtl/tse_cfg_sequencer_if.sv
// tse_cfg_sequencer_if
//   Avalon-MM master bundle between the TSE configuration sequencer and the
//   MAC control ports.
//   master modport: drives address/read/write/writedata, samples readdata and
//                   waitrequest (used by the sequencer).
//   slave  modport: the opposite view (interconnect / bench slave model).
interface tse_cfg_sequencer_if;
  logic [7:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/tse_cfg_sequencer.sv
// tse_cfg_sequencer
//   Post-reset configuration controller for the two TSE MACs. Through one
//   shared Avalon-MM master it soft-resets each MAC, polls for SW_RESET to
//   clear, writes the station address and max frame length, then enables
//   TX/RX (optionally promiscuous). cfg_done rises when both MACs are
//   enabled; a failure stops in ERROR with cfg_error and err_step.
//
//   Optional feature: define TSE_CFG_VERIFY_EN to read back and compare each
//   register written in steps 2-5 (step 5 compares bits 4,1,0 only).
//
// Ports
//   sys_clk, core_reset_n  clock, async active-low reset
//   start                  1-cycle pulse, re-runs the sequence from DONE/ERROR
//   avm (master modport)   Avalon-MM master: address/read/write/writedata out,
//                          readdata/waitrequest in
//   busy                   sequence in progress (0 in DONE/ERROR and in reset)
//   cfg_done               both MACs configured (sticky)
//   cfg_error              sequence aborted (sticky)
//   err_step               {mac_idx, step} of the failing step, 0 otherwise
module tse_cfg_sequencer #(
  parameter logic [7:0]  MAC_BASE0  = 8'h00,
  parameter logic [7:0]  MAC_BASE1  = 8'h80,
  parameter logic [47:0] MAC_ADDR   = 48'h001C23174ACB,
  parameter logic [15:0] FRM_LENGTH = 16'd1518,
  parameter bit          PROMISC    = 1'b1,
  parameter logic [15:0] RST_WAIT   = 16'd1000,
  parameter logic [7:0]  POLL_MAX   = 8'd64
) (
  input  logic                       sys_clk,
  input  logic                       core_reset_n,
  input  logic                       start,
  tse_cfg_sequencer_if.master        avm,
  output logic                       busy,
  output logic                       cfg_done,
  output logic                       cfg_error,
  output logic [3:0]                 err_step
);

  localparam logic [7:0]  OFF_CMD  = 8'h02;
  localparam logic [7:0]  OFF_MAC0 = 8'h03;
  localparam logic [7:0]  OFF_MAC1 = 8'h04;
  localparam logic [7:0]  OFF_FRM  = 8'h05;

  localparam logic [31:0] SW_RESET = 32'h0000_2000;
  localparam logic [31:0] CMD_EN   = 32'h0000_0003 | (PROMISC ? 32'h0000_0010 : 32'h0);
  // byte0 of the station address sits in MAC_ADDR[47:40]
  localparam logic [31:0] MAC0_WORD = {MAC_ADDR[23:16], MAC_ADDR[31:24],
                                       MAC_ADDR[39:32], MAC_ADDR[47:40]};
  localparam logic [31:0] MAC1_WORD = {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]};
  localparam logic [31:0] FRM_WORD  = {16'h0, FRM_LENGTH};

  typedef enum logic [2:0] {
    ST_WAIT, ST_ACCESS, ST_NEXT, ST_DONE, ST_ERROR
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  step, step_n;
  logic        mac_idx, mac_n;
  logic        rb, rb_n;        // current access is a verify readback
  logic [7:0]  poll_cnt, poll_n;
  logic        done_n, err_n, busy_n;
  logic [3:0]  err_step_n;
  logic        adv, fail;

  // ---------------- access decode ----------------
  logic [7:0]  base, off;
  logic [31:0] wdata;
  logic        is_read;

  always_comb begin
    base  = mac_idx ? MAC_BASE1 : MAC_BASE0;
    off   = OFF_CMD;
    wdata = '0;
    unique case (step)
      3'd0:    wdata = SW_RESET;
      3'd2:    begin off = OFF_MAC0; wdata = MAC0_WORD; end
      3'd3:    begin off = OFF_MAC1; wdata = MAC1_WORD; end
      3'd4:    begin off = OFF_FRM;  wdata = FRM_WORD;  end
      3'd5:    wdata = CMD_EN;
      default: ;
    endcase
  end

  assign is_read = (step == 3'd1) || rb;

  // Strobes decode straight from the state register, so an async reset
  // (state -> WAIT) drops them immediately and they hold while stalled.
  assign avm.avm_address   = base + off;
  assign avm.avm_writedata = is_read ? 32'h0 : wdata;
  assign avm.avm_write     = (state == ST_ACCESS) && !is_read;
  assign avm.avm_read      = (state == ST_ACCESS) && is_read;

`ifdef TSE_CFG_VERIFY_EN
  // the enable write is only checked on the bits this block owns
  logic [31:0] cmp_mask;
  assign cmp_mask = (step == 3'd5) ? 32'h0000_0013 : 32'hFFFF_FFFF;
`endif

  // ---------------- next state ----------------
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    step_n     = step;
    mac_n      = mac_idx;
    rb_n       = rb;
    poll_n     = poll_cnt;
    done_n     = cfg_done;
    err_n      = cfg_error;
    err_step_n = err_step;
    adv        = 1'b0;
    fail       = 1'b0;

    unique case (state)
      ST_WAIT: begin
        if (cnt == 16'd0) state_n = ST_ACCESS;
        else              cnt_n   = cnt - 16'd1;
      end
      ST_ACCESS: begin
        if (!avm.avm_waitrequest) begin
          // NEXT gives the mandatory idle cycle between transfers
          state_n = ST_NEXT;
          if (rb) begin
`ifdef TSE_CFG_VERIFY_EN
            rb_n = 1'b0;
            if (((avm.avm_readdata ^ wdata) & cmp_mask) != 32'h0) fail = 1'b1;
            else                                                 adv  = 1'b1;
`endif
          end else if (step == 3'd1) begin
            poll_n = poll_cnt + 8'd1;
            if ((avm.avm_readdata & SW_RESET) == 32'h0) adv  = 1'b1;
            else if (poll_cnt + 8'd1 >= POLL_MAX)       fail = 1'b1;
          end
`ifdef TSE_CFG_VERIFY_EN
          else if (step >= 3'd2) rb_n = 1'b1;
`endif
          else adv = 1'b1;
        end
      end
      ST_NEXT: state_n = ST_ACCESS;
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n    = ST_WAIT;
          cnt_n      = RST_WAIT;
          step_n     = 3'd0;
          mac_n      = 1'b0;
          rb_n       = 1'b0;
          poll_n     = 8'd0;
          done_n     = 1'b0;
          err_n      = 1'b0;
          err_step_n = 4'd0;
        end
      end
      default: state_n = ST_WAIT;
    endcase

    if (adv) begin
      if (step == 3'd5) begin
        if (mac_idx) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          mac_n  = 1'b1;
          step_n = 3'd0;
        end
      end else begin
        step_n = step + 3'd1;
        if (step == 3'd0) poll_n = 8'd0;
      end
    end

    if (fail) begin
      state_n    = ST_ERROR;
      err_n      = 1'b1;
      err_step_n = {mac_idx, step};
    end

    busy_n = (state_n != ST_DONE) && (state_n != ST_ERROR);
  end

  // ---------------- state register ----------------
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state     <= ST_WAIT;
      cnt       <= RST_WAIT;
      step      <= 3'd0;
      mac_idx   <= 1'b0;
      rb        <= 1'b0;
      poll_cnt  <= 8'd0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      err_step  <= 4'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      mac_idx   <= mac_n;
      rb        <= rb_n;
      poll_cnt  <= poll_n;
      busy      <= busy_n;
      cfg_done  <= done_n;
      cfg_error <= err_n;
      err_step  <= err_step_n;
    end
  end

endmodule
